instr_decode: RTL

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/mips_defs.sv | 22 ++
 rtl/instr_decode_reg_file.sv | 60 ++++++
 rtl/instr_decode.sv | 73 +++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct encodings, register indices and immediate-extension helper
// used by the decode stage and its register file.
package mips_defs;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] J      = 6'h02;

    localparam logic [4:0] ZERO = 5'd0;
    localparam logic [4:0] GP   = 5'd28;
    localparam logic [4:0] SP   = 5'd29;

    localparam int NUM_REGS = 32;

    function automatic logic [31:0] extend_imm16(input logic [15:0] imm16, input logic sign_ext);
        return sign_ext ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
    endfunction

endpackage

// File: rtl/instr_decode_reg_file.sv
// 32-entry register file: two asynchronous read ports with write-through bypass,
// one synchronous write port, $0 hardwired to zero, $28/$29 preset on reset.
module reg_file
    import mips_defs::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h7FFF_EFFC),
    parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(32'h1000_8000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        ra_addr,
    input  logic [4:0]        rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_en;

    // Gating with rst_n keeps the bypass from showing data that will never be written.
    assign wr_en = we && (wr_addr != ZERO) && rst_n;

    function automatic logic [DATA_W-1:0] reset_value(input logic [4:0] idx);
        if (idx == SP) return SP_INIT;
        if (idx == GP) return GP_INIT;
        return '0;
    endfunction

    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
        if (addr == ZERO)                return '0;
        if (wr_en && (addr == wr_addr))  return wr_data;
        return regs_q[addr];
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reset_value(5'(i));
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data = read_port(ra_addr);
    assign rb_data = read_port(rb_addr);

endmodule

// File: rtl/instr_decode.sv
// Instruction decode stage: combinational field slicing and immediate extension,
// register-file reads for rs/rt, and a free-running retired-cycle counter.
module instr_decode
    import mips_defs::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h7FFF_EFFC),
    parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(32'h1000_8000)
) (
    input  logic              clk,
    input  logic              start_up_n,
    input  logic [31:0]       instruction,
    input  logic              ext_op,
    input  logic              reg_wr,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [31:0]       imm32,
    output logic [25:0]       target26,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    output logic [31:0]       retired
);

    logic [31:0] retired_q;
    logic [31:0] retired_d;

    assign opcode   = instruction[31:26];
    assign rs       = instruction[25:21];
    assign rt       = instruction[20:16];
    assign rd       = instruction[15:11];
    assign shamt    = instruction[10:6];
    assign funct    = instruction[5:0];
    assign target26 = instruction[25:0];
    assign imm32    = extend_imm16(instruction[15:0], ext_op);

    reg_file #(
        .DATA_W  (DATA_W),
        .SP_INIT (SP_INIT),
        .GP_INIT (GP_INIT)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (start_up_n),
        .we      (reg_wr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ra_addr (rs),
        .rb_addr (rt),
        .ra_data (bus_a),
        .rb_data (bus_b)
    );

    // Wraps naturally at 2^32; every cycle retires one instruction.
    always_comb begin
        retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk or negedge start_up_n) begin
        if (!start_up_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule
